dcache_controller: RTL
======================

# dcache_controller

Direct-mapped, write-back data cache controller between the CPU load/store path (lwd, lwi, swd, swi) and the multi-cycle data memory. It holds 8 lines of 4-byte blocks and serves byte accesses from the CPU. Misses are handled by sequencing dirty-line write-back and block fetch over the memory port. The CPU is stalled through BUSYWAIT.

## Interface
Parameters:
- LINES, 8, number of cache lines (power of 2)
- BLOCK_BYTES, 4, bytes per line (fixed 4; memory port is 32 bits)

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- READ  in  1  CPU load request, held until BUSYWAIT low
- WRITE  in  1  CPU store request, held until BUSYWAIT low
- ADDRESS  in  8  CPU byte address: tag[7:5], index[4:2], offset[1:0]
- WRITEDATA  in  8  CPU store data
- READDATA  out  8  CPU load data
- BUSYWAIT  out  1  CPU stall
- MEM_READ  out  1  block fetch strobe
- MEM_WRITE  out  1  block write-back strobe
- MEM_ADDRESS  out  6  block address {tag,index}
- MEM_WRITEDATA  out  32  write-back block
- MEM_READDATA  in  32  fetched block
- MEM_BUSYWAIT  in  1  memory busy; low for one cycle on completion

## Operation
- Per line: valid, dirty, tag[2:0], data[31:0]. Byte k of a block is data[8k+7:8k].
- Hit = valid[index] and tag match. Lookup is combinational from ADDRESS.
- WRITE and READ together: WRITE takes priority. Neither asserted: BUSYWAIT=0, no state change.
- FSM states:
  - IDLE: on a request that misses, go to WRITEBACK if dirty[index], else FETCH.
  - WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={stored tag,index}, MEM_WRITEDATA=line data. When MEM_BUSYWAIT=0, go to FETCH.
  - FETCH: MEM_READ=1, MEM_ADDRESS={ADDRESS tag,index}. When MEM_BUSYWAIT=0, go to UPDATE.
  - UPDATE: one cycle. Latch MEM_READDATA into the line, set valid=1, dirty=0, load the tag. Return to IDLE.
- In IDLE, the reissued access now hits.
- Read hit: READDATA=selected byte and BUSYWAIT=0 in the same cycle.
- Write hit: BUSYWAIT=0. At the next rising edge, write the byte into the line and set dirty=1.
- Memory strobes are asserted only in WRITEBACK and FETCH. They are never asserted together.

## Timing
- BUSYWAIT = (READ|WRITE) & (state≠IDLE | miss), combinational.
- Hit latency: 0 extra cycles. The access completes at the first rising edge.
- Clean-miss latency: FETCH for (memory latency) cycles, plus 1 UPDATE cycle, plus 1 IDLE hit cycle.
- Dirty-miss latency: adds the WRITEBACK duration.
- Reset values: READDATA=0, BUSYWAIT=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
- Reset also sets state=IDLE and clears all valid and dirty bits. Data and tag contents are don't-care.
- Reset during WRITEBACK or FETCH aborts immediately. Strobes drop asynchronously and the lost write-back is not retried.
- Requests that change while BUSYWAIT=1 are a protocol violation. Behaviour is unspecified.

## Configuration
- DCACHE_STATS_EN defined:
  - Adds outputs HIT_COUNT[15:0] and MISS_COUNT[15:0], both reset to 0.
  - HIT_COUNT increments once per completed access that hit on first lookup.
  - MISS_COUNT increments on each IDLE→WRITEBACK or IDLE→FETCH transition.
  - Both counters saturate at 16'hFFFF.
- DCACHE_STATS_EN undefined: no counter ports or logic. Behaviour is otherwise identical.

## Structure
- Package dcache_pkg:
  - state encoding IDLE=0, WRITEBACK=1, FETCH=2, UPDATE=3
  - TAG_W=3, INDEX_W=3, OFFSET_W=2, BLOCK_W=32
- Sub-module dcache_line_array holds valid, dirty, tag and data storage:
  - asynchronous read port
  - synchronous byte-write and block-fill ports
  - asynchronous clear of valid and dirty on RESET_N
- dcache_controller holds the FSM, hit logic and BUSYWAIT.

## Test plan
- Reset, then READ of ADDRESS 8'h05 with memory block 6'h01 = 32'hDDCCBBAA:
  - FETCH issued with MEM_ADDRESS=6'h01.
  - Returns READDATA=8'hBB after UPDATE.
  - MISS_COUNT=1.
- Same READ repeated: BUSYWAIT stays 0 and READDATA=8'hBB with no memory strobe. HIT_COUNT increments.
- WRITE 8'h5A to 8'h06 (hit): completes in one cycle and the line becomes dirty. A later READ of 8'h06 returns 8'h5A.
- READ of 8'h25 (same index, tag 1):
  - WRITEBACK with MEM_ADDRESS=6'h01 and MEM_WRITEDATA=32'hDD5ABBAA.
  - Then FETCH with MEM_ADDRESS=6'h09.
- RESET_N asserted low mid-FETCH:
  - MEM_READ and BUSYWAIT drop immediately.
  - Next READ of 8'h05 misses, confirming valid bits were cleared.
- READ and WRITE both asserted on a hit to 8'h00 with WRITEDATA=8'h11: the write is performed and the line is dirty.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and widths for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int TAG_W    = 3;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;
  localparam int BLOCK_W  = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    UPDATE    = 2'd3
  } state_e;

  function automatic logic [7:0] get_byte(input logic [BLOCK_W-1:0] blk,
                                          input logic [OFFSET_W-1:0] off);
    get_byte = blk[{off, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Valid/dirty/tag/data storage: async read, sync byte write and block fill,
// async clear of valid and dirty.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int LINES       = 8,
  parameter int BLOCK_BYTES = 4
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic [INDEX_W-1:0]         i_index,
  output logic                       o_valid,
  output logic                       o_dirty,
  output logic [TAG_W-1:0]           o_tag,
  output logic [8*BLOCK_BYTES-1:0]   o_data,
  input  logic                       i_wr_en,
  input  logic [OFFSET_W-1:0]        i_wr_off,
  input  logic [7:0]                 i_wr_byte,
  input  logic                       i_fill_en,
  input  logic [TAG_W-1:0]           i_fill_tag,
  input  logic [8*BLOCK_BYTES-1:0]   i_fill_data
);

  logic [LINES-1:0]         r_valid;
  logic [LINES-1:0]         r_dirty;
  logic [TAG_W-1:0]         r_tag  [LINES];
  logic [8*BLOCK_BYTES-1:0] r_data [LINES];

  assign o_valid = r_valid[i_index];
  assign o_dirty = r_dirty[i_index];
  assign o_tag   = r_tag[i_index];
  assign o_data  = r_data[i_index];

  // Line status bits; a fill always leaves the line clean.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_valid <= {LINES{1'b0}};
      r_dirty <= {LINES{1'b0}};
    end else if (i_fill_en) begin
      r_valid[i_index] <= 1'b1;
      r_dirty[i_index] <= 1'b0;
    end else if (i_wr_en) begin
      r_dirty[i_index] <= 1'b1;
    end
  end

  // Tag and data payload need no reset; valid gates their use.
  always_ff @(posedge CLK) begin
    if (i_fill_en) begin
      r_tag[i_index]  <= i_fill_tag;
      r_data[i_index] <= i_fill_data;
    end else if (i_wr_en) begin
      r_data[i_index][{i_wr_off, 3'b000} +: 8] <= i_wr_byte;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache controller (8 lines x 4 bytes).
// Optional hit/miss counters are enabled with `define DCACHE_STATS_EN.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int LINES       = 8,
  parameter int BLOCK_BYTES = 4
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       READ,
  input  logic                       WRITE,
  input  logic [7:0]                 ADDRESS,
  input  logic [7:0]                 WRITEDATA,
  output logic [7:0]                 READDATA,
  output logic                       BUSYWAIT,
  output logic                       MEM_READ,
  output logic                       MEM_WRITE,
  output logic [TAG_W+INDEX_W-1:0]   MEM_ADDRESS,
  output logic [BLOCK_W-1:0]         MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]         MEM_READDATA,
  input  logic                       MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]                HIT_COUNT,
  output logic [15:0]                MISS_COUNT
`endif
);

  state_e                    r_state;
  logic                      r_mem_read;
  logic                      r_mem_write;
  logic [TAG_W+INDEX_W-1:0]  r_mem_addr;
  logic [BLOCK_W-1:0]        r_mem_wdata;

  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_index;
  logic [OFFSET_W-1:0] w_off;
  logic                w_valid;
  logic                w_dirty;
  logic [TAG_W-1:0]    w_line_tag;
  logic [BLOCK_W-1:0]  w_line_data;
  logic                w_req;
  logic                w_hit;
  logic                w_idle;
  logic                w_wr_hit;
  logic                w_fill;

  assign w_tag    = ADDRESS[7:5];
  assign w_index  = ADDRESS[4:2];
  assign w_off    = ADDRESS[1:0];
  assign w_req    = READ | WRITE;
  assign w_hit    = w_valid & (w_line_tag == w_tag);
  assign w_idle   = (r_state == IDLE);
  assign w_wr_hit = w_idle & WRITE & w_hit;
  assign w_fill   = (r_state == UPDATE);

  dcache_line_array #(
    .LINES       (LINES),
    .BLOCK_BYTES (BLOCK_BYTES)
  ) u_lines (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .i_index     (w_index),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty),
    .o_tag       (w_line_tag),
    .o_data      (w_line_data),
    .i_wr_en     (w_wr_hit),
    .i_wr_off    (w_off),
    .i_wr_byte   (WRITEDATA),
    .i_fill_en   (w_fill),
    .i_fill_tag  (w_tag),
    .i_fill_data (MEM_READDATA)
  );

  // BUSYWAIT is gated by RESET_N so the CPU is released the moment reset hits.
  assign BUSYWAIT      = RESET_N & w_req & (~w_idle | ~w_hit);
  assign READDATA      = w_hit ? get_byte(w_line_data, w_off) : 8'h00;
  assign MEM_READ      = r_mem_read;
  assign MEM_WRITE     = r_mem_write;
  assign MEM_ADDRESS   = r_mem_addr;
  assign MEM_WRITEDATA = r_mem_wdata;

  // Miss sequencer; MEM_ADDRESS is held through UPDATE so fill data stays valid.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= IDLE;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= {(TAG_W+INDEX_W){1'b0}};
      r_mem_wdata <= {BLOCK_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && !w_hit) begin
            if (w_dirty) begin
              r_state     <= WRITEBACK;
              r_mem_write <= 1'b1;
              r_mem_addr  <= {w_line_tag, w_index};
              r_mem_wdata <= w_line_data;
            end else begin
              r_state    <= FETCH;
              r_mem_read <= 1'b1;
              r_mem_addr <= {w_tag, w_index};
            end
          end
        end
        WRITEBACK: begin
          if (!MEM_BUSYWAIT) begin
            r_state     <= FETCH;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b1;
            r_mem_addr  <= {w_tag, w_index};
          end
        end
        FETCH: begin
          if (!MEM_BUSYWAIT) begin
            r_state    <= UPDATE;
            r_mem_read <= 1'b0;
          end
        end
        UPDATE: r_state <= IDLE;
        default: begin
          r_state     <= IDLE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic        r_missed;
  logic [15:0] r_hit_count;
  logic [15:0] r_miss_count;

  assign HIT_COUNT  = r_hit_count;
  assign MISS_COUNT = r_miss_count;

  // r_missed marks the reissued access after a miss so it is not counted as a hit.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_missed     <= 1'b0;
      r_hit_count  <= 16'h0000;
      r_miss_count <= 16'h0000;
    end else if (w_idle && w_req && !w_hit) begin
      r_missed <= 1'b1;
      if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
    end else if (w_idle && w_req && w_hit) begin
      r_missed <= 1'b0;
      if (!r_missed && r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
    end
  end
`endif

endmodule
